pair_triple_window_collector: RTL and testbench
===============================================

// Module: pair_triple_window_collector
//
// PURPOSE
//  Upstream feeder for the pair/triple (2-of-3 majority) detector. Collects a
//  serial bit stream into 3-bit windows and presents each complete window as
//  in0/in1/in2 using a val/rdy handshake.
//  Also computes the window's majority bit and keeps a saturating count of
//  accepted windows whose majority is 1.
//  Sits between a serial source and the combinational detector/consumer.
//
// PARAMETERS
//  CNT_W   8   width of maj_count (saturating)
//  SLIDE   0   0 = non-overlapping windows; 1 = sliding window (step of 1 bit)
//
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_val     in   1      serial bit valid
//  in_rdy     out  1      collector can accept in_bit this cycle
//  in_bit     in   1      serial data bit
//  flush      in   1      discard any partial or full window
//  out_val    out  1      complete window available
//  out_rdy    in   1      consumer accepts window this cycle
//  out_in0    out  1      oldest bit of window
//  out_in1    out  1      middle bit of window
//  out_in2    out  1      newest bit of window
//  out_maj    out  1      (in0&in1)|(in0&in2)|(in1&in2) of presented window
//  maj_count  out  CNT_W  number of transferred windows with out_maj=1
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=EMPTY, window bits=0, maj_count=0,
//    out_val=0, in_rdy=1.
//  - Input fire = in_val & in_rdy. Output fire = out_val & out_rdy.
//  - FSM states: EMPTY -> HAS1 -> HAS2 -> FULL, advancing one state per input fire.
//  - Bit order: 1st accepted bit goes to in0, 2nd to in1, 3rd to in2.
//    In sliding mode, each shift moves in1->in0, in2->in1, and new->in2.
//  - out_val = (state==FULL). Window bits are held stable while out_val=1
//    and out_rdy=0.
//  - in_rdy = (state!=FULL) | out_rdy. This allows same-cycle consume and refill.
//  - FULL, output fire, no input fire:
//      SLIDE=0 -> EMPTY; SLIDE=1 -> HAS2, keeping in1/in2 as the new in0/in1.
//  - FULL, output fire and input fire in the same cycle:
//      SLIDE=0 -> HAS1, with the new bit in in0.
//      SLIDE=1 -> stays FULL with the shifted window. out_val stays 1 and the
//      next window is presented on the following cycle.
//  - Latency: the 3rd input fire at cycle N gives out_val=1 at cycle N+1.
//    No combinational path from in_* to out_*.
//  - out_maj is combinational from the registered window bits. It is
//    meaningful only when out_val=1; otherwise it reflects the stale register.
//  - maj_count increments by 1 on output fire when out_maj=1. It saturates at
//    2^CNT_W-1 and does not wrap.
//  - flush=1 (synchronous): next state is EMPTY regardless of handshakes, and
//    window bits are cleared to 0.
//    * in_rdy is forced to 0 and out_val is unaffected in the flush cycle.
//    * An output fire in that cycle still counts toward maj_count.
//    * maj_count is not cleared by flush.
//  - Reset asserted mid-window discards all state immediately (async).
//    The first bit accepted after reset deassertion lands in in0.
//  - X on in_bit while in_val=1 propagates to the window and out_maj.
//    X on handshake inputs is not required to be handled.
//
// STRUCTURE
//  - Shared package: state typedef {EMPTY, HAS1, HAS2, FULL} (2-bit enum).
//  - One sub-module: pair_triple_maj3, a combinational 2-of-3 majority used
//    for out_maj, interface-compatible with the existing detector.
//  - Remaining logic: FSM, 3-bit window register, saturating counter.
//
// TESTING
//  1. Reset, SLIDE=0, feed 0,1,1 with out_rdy=1
//     -> window in0..2=0,1,1 valid at cycle 4; out_maj=1; maj_count=1.
//  2. SLIDE=0, feed 1,0,0 then 1,0,1 with out_rdy=0 after the 3rd bit
//     -> in_rdy=0 and window 1,0,0 held stable. Raise out_rdy
//     -> maj_count unchanged, then window 1,0,1 (maj=1), count +1.
//  3. SLIDE=1, feed 1,1,0,0,0 with out_rdy=1
//     -> windows 110, 100, 000; out_maj=1,0,0; maj_count=1.
//  4. Feed 1,1 then flush
//     -> state EMPTY. Feed 0,0,0 -> window 000; out_maj=0.
//  5. CNT_W=2: transfer five windows of 1,1,1
//     -> maj_count reads 1,2,3,3,3 (saturates).
//  6. Assert rst_n=0 mid-window between clock edges
//     -> out_val=0 and maj_count=0 immediately; the next accepted bit lands in in0.

Source files
------------

// File: rtl/pair_triple_window_collector_pkg.sv
// Shared types for the pair/triple window collector: window-fill FSM states.
package pair_triple_window_collector_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAS1  = 2'd1,
    HAS2  = 2'd2,
    FULL  = 2'd3
  } state_e;

endpackage

// File: rtl/pair_triple_maj3.sv
// Combinational 2-of-3 majority, port-compatible with the downstream pair/triple detector.
module pair_triple_maj3 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic out
);

  assign out = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/pair_triple_window_collector.sv
// Collects a serial bit stream into 3-bit windows (val/rdy on both sides), reports the
// window majority and a saturating count of transferred windows whose majority is 1.
module pair_triple_window_collector
  import pair_triple_window_collector_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter bit SLIDE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  input  logic             flush,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_in0,
  output logic             out_in1,
  output logic             out_in2,
  output logic             out_maj,
  output logic [CNT_W-1:0] maj_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       win_q, win_d;   // bit 0 = oldest (in0), bit 2 = newest (in2)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire_s;
  logic             out_fire_s;

  assign out_val    = (state_q == FULL);
  assign in_rdy     = ~flush & ((state_q != FULL) | out_rdy);
  assign in_fire_s  = in_val & in_rdy;
  assign out_fire_s = out_val & out_rdy;
  assign out_in0    = win_q[0];
  assign out_in1    = win_q[1];
  assign out_in2    = win_q[2];
  assign maj_count  = cnt_q;

  pair_triple_maj3 u_maj3 (
    .in0 (win_q[0]),
    .in1 (win_q[1]),
    .in2 (win_q[2]),
    .out (out_maj)
  );

  // State, window and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      win_q   <= 3'b000;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  // Window fill/drain sequencing; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    if (flush) begin
      state_d = EMPTY;
      win_d   = 3'b000;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_s) begin
            win_d[0] = in_bit;
            state_d  = HAS1;
          end else begin
            state_d = EMPTY;
          end
        end
        HAS1: begin
          if (in_fire_s) begin
            win_d[1] = in_bit;
            state_d  = HAS2;
          end else begin
            state_d = HAS1;
          end
        end
        HAS2: begin
          if (in_fire_s) begin
            win_d[2] = in_bit;
            state_d  = FULL;
          end else begin
            state_d = HAS2;
          end
        end
        FULL: begin
          // In FULL, an input fire is only possible together with an output fire.
          if (out_fire_s) begin
            if (SLIDE) begin
              win_d[1:0] = win_q[2:1];
              if (in_fire_s) begin
                win_d[2] = in_bit;
                state_d  = FULL;
              end else begin
                state_d = HAS2;
              end
            end else begin
              if (in_fire_s) begin
                win_d[0] = in_bit;
                state_d  = HAS1;
              end else begin
                state_d = EMPTY;
              end
            end
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          win_d   = 3'b000;
        end
      endcase
    end
  end

  // Saturating count of transferred majority-1 windows; flush does not clear it.
  always_comb begin
    if (out_fire_s && out_maj && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_pair_triple_window_collector.sv
// Drives three collector variants (non-overlapping, sliding, 2-bit counter) with directed and
// random stimulus and checks each against a bit-queue model of the window.
module tb_pair_triple_window_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_val = 1'b0;
  logic in_bit = 1'b0;
  logic flush = 1'b0;
  logic out_rdy = 1'b0;

  always #5 clk = ~clk;

  logic       rdy0, val0, i00, i01, i02, maj0;
  logic       rdy1, val1, i10, i11, i12, maj1;
  logic       rdy2, val2, i20, i21, i22, maj2;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;

  pair_triple_window_collector #(.CNT_W(8), .SLIDE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(rdy0), .in_bit(in_bit), .flush(flush),
    .out_val(val0), .out_rdy(out_rdy), .out_in0(i00), .out_in1(i01), .out_in2(i02),
    .out_maj(maj0), .maj_count(mc0));

  pair_triple_window_collector #(.CNT_W(8), .SLIDE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(rdy1), .in_bit(in_bit), .flush(flush),
    .out_val(val1), .out_rdy(out_rdy), .out_in0(i10), .out_in1(i11), .out_in2(i12),
    .out_maj(maj1), .maj_count(mc1));

  pair_triple_window_collector #(.CNT_W(2), .SLIDE(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(rdy2), .in_bit(in_bit), .flush(flush),
    .out_val(val2), .out_rdy(out_rdy), .out_in0(i20), .out_in1(i21), .out_in2(i22),
    .out_maj(maj2), .maj_count(mc2));

  logic        dv[3], dr[3], dm[3];
  logic [2:0]  dw[3];
  logic [31:0] dc[3];
  assign dv[0] = val0; assign dr[0] = rdy0; assign dm[0] = maj0; assign dw[0] = {i02, i01, i00};
  assign dv[1] = val1; assign dr[1] = rdy1; assign dm[1] = maj1; assign dw[1] = {i12, i11, i10};
  assign dv[2] = val2; assign dr[2] = rdy2; assign dm[2] = maj2; assign dw[2] = {i22, i21, i20};
  assign dc[0] = 32'(mc0);
  assign dc[1] = 32'(mc1);
  assign dc[2] = 32'(mc2);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: accepted bits in arrival order (bit i = i-th oldest), fill level, saturating count.
  int         n[3];
  logic [2:0] w[3];
  int         cnt[3];
  int         cmax[3] = '{255, 255, 3};
  bit         slide[3] = '{1'b0, 1'b1, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic ev, er, ifire, ofire, emaj;
      if (!rst_n) begin
        n[k] = 0;
        w[k] = 3'b000;
        cnt[k] = 0;
      end
      ev   = (n[k] == 3);
      er   = !flush && ((n[k] < 3) || out_rdy);
      emaj = ($countones(w[k]) >= 2);
      chk($sformatf("u%0d out_val", k), 32'(dv[k]), 32'(ev));
      chk($sformatf("u%0d in_rdy", k), 32'(dr[k]), 32'(er));
      chk($sformatf("u%0d maj_count", k), dc[k], 32'(cnt[k]));
      if (ev) begin
        chk($sformatf("u%0d window", k), 32'(dw[k]), 32'(w[k]));
        chk($sformatf("u%0d out_maj", k), 32'(dm[k]), 32'(emaj));
      end
      if (rst_n) begin
        ifire = in_val && er;
        ofire = ev && out_rdy;
        if (ofire && emaj && (cnt[k] < cmax[k])) cnt[k]++;
        if (flush) begin
          n[k] = 0;
        end else begin
          if (ofire) begin
            if (slide[k]) begin
              w[k] = w[k] >> 1;
              n[k] = 2;
            end else begin
              n[k] = 0;
            end
          end
          if (ifire) begin
            w[k][n[k]] = in_bit;
            n[k]++;
          end
        end
      end
    end
  end

  task automatic set(input logic v, input logic b, input logic f, input logic r);
    in_val = v; in_bit = b; flush = f; out_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic b, input logic f, input logic r);
    set(v, b, f, r);
    tick();
  endtask

  task automatic do_reset();
    set(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    #3;
    chk("reset out_val", 32'(val0), 32'd0);
    chk("reset in_rdy", 32'(rdy0), 32'd1);
    chk("reset window", 32'({i02, i01, i00}), 32'd0);
    chk("reset maj_count", 32'(mc0), 32'd0);
    do_reset();

    // Test 1: 0,1,1 non-overlapping.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t1 out_val", 32'(val0), 32'd1);
    chk("t1 window", 32'({i02, i01, i00}), 32'b110);
    chk("t1 out_maj", 32'(maj0), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1 maj_count", 32'(mc0), 32'd1);

    // Test 2: back-pressure holds 1,0,0, then 1,0,1 follows.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    set(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t2 in_rdy stalled", 32'(rdy0), 32'd0);
    tick();
    tick();
    chk("t2 held window", 32'({i02, i01, i00}), 32'b001);
    chk("t2 held out_val", 32'(val0), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2 count after maj0", 32'(mc0), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2 window 101", 32'({i02, i01, i00}), 32'b101);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2 maj_count", 32'(mc0), 32'd2);

    // Test 3: sliding 1,1,0,0,0.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3 win110", 32'({i12, i11, i10}), 32'b011);
    chk("t3 maj 1", 32'(maj1), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3 win100", 32'({i12, i11, i10}), 32'b001);
    chk("t3 maj 0", 32'(maj1), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3 win000", 32'({i12, i11, i10}), 32'b000);
    chk("t3 still valid", 32'(val1), 32'd1);
    chk("t3 maj_count", 32'(mc1), 32'd1);

    // Test 4: flush discards a partial window.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    set(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("t4 in_rdy flush", 32'(rdy0), 32'd0);
    tick();
    chk("t4 flushed window", 32'({i02, i01, i00}), 32'b000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4 not yet full", 32'(val0), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4 out_val", 32'(val0), 32'd1);
    chk("t4 out_maj", 32'(maj0), 32'd0);

    // Test 5: saturation of a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("t5 sat count %0d", i), 32'(mc2), 32'(sat_exp[i]));
    end
    chk("t5 wide count", 32'(mc0), 32'd5);

    // Test 6: asynchronous reset in the middle of a held window.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6 pre count", 32'(mc0), 32'd1);
    chk("t6 pre val", 32'(val0), 32'd1);
    set(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async val", 32'(val0), 32'd0);
    chk("t6 async count", 32'(mc0), 32'd0);
    tick();
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6 first bit in in0", 32'({i02, i01, i00}), 32'b001);

    // Random phase: model-checked every cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
